// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR flip-flop driver: FSM states and {S,R} excitation codes.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sr_ff_pkg;

  // The state values are fixed so that debug dumps of state_q read the same in every build.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  // Excitation codes packed as {S,R}. There is no 2'b11 code, so S=R=1 has no encoding.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_RST  = 2'b01;

endpackage

// File: rtl/sr_excitation.sv
// SR excitation table: chooses {S,R} that moves a flip-flop from cur_q_i to tgt_q_i.
// Latency: combinational.
// Backpressure: n/a.
// Ports: known_i (cur_q_i is trustworthy), cur_q_i, tgt_q_i -> sr_o = {S,R}.
module sr_excitation
  import sr_ff_pkg::*;
(
  input  logic       known_i,
  input  logic       cur_q_i,
  input  logic       tgt_q_i,
  output logic [1:0] sr_o
);

  always_comb begin
    sr_o = EXC_HOLD;
    // A hold is only safe when the flip-flop state is actually known. Otherwise the
    // target is forced explicitly.
    if (known_i && (tgt_q_i == cur_q_i)) begin
      sr_o = EXC_HOLD;
    end else if (tgt_q_i) begin
      sr_o = EXC_SET;
    end else begin
      sr_o = EXC_RST;
    end
  end

endmodule

// File: rtl/sr_ff_driver.sv
// Drives an external gated SR flip-flop toward each requested Q, then checks Q/QBar.
// Latency: accept at cycle 0, FfEn at cycle 1, Done at cycle 2+SETTLE_CYCLES.
// Backpressure: TgtReady is high only in IDLE. A held TgtValid waits there, with no buffering.
// Ports: Clk/Rst (synchronous, active-high); TgtValid/TgtQ/TgtReady request handshake;
//   S/R/FfEn to the flip-flop; Q/QBar from it; Done/Match/Fault check result;
//   ErrCnt count of non-matching checks, present only when SR_ERR_COUNT_EN is defined.
module sr_ff_driver
  import sr_ff_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
`ifdef SR_ERR_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic Clk,
  input  logic Rst,
  input  logic TgtValid,
  input  logic TgtQ,
  output logic TgtReady,
  output logic S,
  output logic R,
  output logic FfEn,
  input  logic Q,
  input  logic QBar,
  output logic Done,
  output logic Match,
  output logic Fault
`ifdef SR_ERR_COUNT_EN
  , output logic [CNT_W-1:0] ErrCnt
`endif
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic       tgt_q_q;
  logic       cur_q_q;
  logic       known_q;
  logic [3:0] settle_cnt_q;
  logic       s_q, r_q, ffen_q;
  logic       rdy_q;
  logic       done_q, match_q, fault_q;
`ifdef SR_ERR_COUNT_EN
  logic [CNT_W-1:0] errcnt_q;
`endif

  logic [1:0] exc_sr;
  logic       fault_d;
  logic       match_d;

  // The excitation uses the live TgtQ because {S,R} is registered on the same edge that
  // accepts the target.
  sr_excitation u_exc (
    .known_i (known_q),
    .cur_q_i (cur_q_q),
    .tgt_q_i (TgtQ),
    .sr_o    (exc_sr)
  );

  // Q/QBar are evaluated on the last SETTLE edge. The registered result is presented
  // during CHECK together with Done.
  assign fault_d = (Q == QBar);
  assign match_d = (Q == tgt_q_q) & ~fault_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      tgt_q_q      <= 1'b0;
      cur_q_q      <= 1'b0;
      known_q      <= 1'b0;
      settle_cnt_q <= 4'd0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      ffen_q       <= 1'b0;
      rdy_q        <= 1'b1;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      fault_q      <= 1'b0;
`ifdef SR_ERR_COUNT_EN
      errcnt_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (TgtValid && rdy_q) begin
            tgt_q_q      <= TgtQ;
            {s_q, r_q}   <= exc_sr;
            ffen_q       <= 1'b1;
            rdy_q        <= 1'b0;
            state_q      <= DRIVE;
          end
        end
        DRIVE: begin
          s_q          <= 1'b0;
          r_q          <= 1'b0;
          ffen_q       <= 1'b0;
          settle_cnt_q <= SETTLE_INIT;
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            match_q <= match_d;
            fault_q <= fault_d;
            cur_q_q <= tgt_q_q;
            // An illegal output pair means the real state is unknown. The next command
            // must therefore excite the flip-flop explicitly.
            known_q <= ~fault_d;
`ifdef SR_ERR_COUNT_EN
            if (!match_d && (errcnt_q != '1)) begin
              errcnt_q <= errcnt_q + CNT_W'(1);
            end
`endif
            state_q <= CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        CHECK: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TgtReady = rdy_q;
  assign S        = s_q;
  assign R        = r_q;
  assign FfEn     = ffen_q;
  assign Done     = done_q;
  assign Match    = match_q;
  assign Fault    = fault_q;
`ifdef SR_ERR_COUNT_EN
  assign ErrCnt   = errcnt_q;
`endif

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver. Two instances are used: SETTLE_CYCLES=1 and SETTLE_CYCLES=3.
// Each instance has its own behavioural gated SR flip-flop. The first flip-flop can be
// stuck at Q=QBar=0.
module tb_sr_ff_driver;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  integer total = 0;
  integer bad   = 0;

  // Instance 1: SETTLE_CYCLES = 1
  logic tv = 1'b0, tq = 1'b0;
  logic rdy, s, r, en, q, qb, done, match, fault;
  logic ffq, stuck = 1'b0;
  // Instance 3: SETTLE_CYCLES = 3
  logic tv3 = 1'b0, tq3 = 1'b0;
  logic rdy3, s3, r3, en3, q3, qb3, done3, match3, fault3;
  logic ffq3;
`ifdef SR_ERR_COUNT_EN
  logic [7:0] errcnt, errcnt3;
`endif

  sr_ff_driver #(.SETTLE_CYCLES(1)) dut (
    .Clk(Clk), .Rst(Rst), .TgtValid(tv), .TgtQ(tq), .TgtReady(rdy),
    .S(s), .R(r), .FfEn(en), .Q(q), .QBar(qb),
    .Done(done), .Match(match), .Fault(fault)
`ifdef SR_ERR_COUNT_EN
    , .ErrCnt(errcnt)
`endif
  );

  sr_ff_driver #(.SETTLE_CYCLES(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .TgtValid(tv3), .TgtQ(tq3), .TgtReady(rdy3),
    .S(s3), .R(r3), .FfEn(en3), .Q(q3), .QBar(qb3),
    .Done(done3), .Match(match3), .Fault(fault3)
`ifdef SR_ERR_COUNT_EN
    , .ErrCnt(errcnt3)
`endif
  );

  // Gated SR flip-flop models
  always @(posedge Clk) begin
    if (stuck) ffq <= 1'b0;
    else if (en) begin
      if (s && !r) ffq <= 1'b1;
      else if (r && !s) ffq <= 1'b0;
    end
  end
  assign q  = ffq;
  assign qb = stuck ? 1'b0 : ~ffq;

  always @(posedge Clk) begin
    if (en3) begin
      if (s3 && !r3) ffq3 <= 1'b1;
      else if (r3 && !s3) ffq3 <= 1'b0;
    end
  end
  assign q3  = ffq3;
  assign qb3 = ~ffq3;

  // S=R=1 must never appear on either instance.
  always @(negedge Clk) begin
    if (s && r) begin
      bad = bad + 1;
      $display("FAIL sr_both_high dut: S=%b R=%b required not both 1", s, r);
    end
    if (s3 && r3) begin
      bad = bad + 1;
      $display("FAIL sr_both_high dut3: S=%b R=%b required not both 1", s3, r3);
    end
  end

  // Issues one target to instance 1 from an IDLE cycle and records what it observes.
  // The task returns just after the edge that leaves CHECK. done_cyc is -1 if no Done is seen.
  task automatic issue(input logic tgt, output logic so, output logic ro, output logic eo,
                       output int done_cyc, output logic mo, output logic fo);
    tv = 1'b1; tq = tgt;
    @(negedge Clk);                 // cycle 0
    @(posedge Clk); #1 tv = 1'b0;
    @(negedge Clk);                 // cycle 1
    so = s; ro = r; eo = en;
    done_cyc = -1; mo = 1'bx; fo = 1'bx;
    for (int c = 2; c < 20; c++) begin
      @(negedge Clk);
      if (done) begin
        done_cyc = c; mo = match; fo = fault;
        break;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total = total + 1;
    if ({s, r, en, done, match, fault} !== 6'b0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs: S,R,FfEn,Done,Match,Fault=%b required 000000",
               {s, r, en, done, match, fault});
    end
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    total = total + 1;
    if (rdy !== 1'b1 || done !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_ready: TgtReady=%b Done=%b required 1 0", rdy, done);
    end
`ifdef SR_ERR_COUNT_EN
    total = total + 1;
    if (errcnt !== 8'd0) begin
      bad = bad + 1;
      $display("FAIL reset_errcnt: ErrCnt=%0d required 0", errcnt);
    end
`endif
    @(posedge Clk); #1;
  endtask

  task automatic test_set_hold_reset;
    logic so, ro, eo, mo, fo;
    int dc;
    // First target after reset: explicit set, and Done at cycle 3
    issue(1'b1, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if ({so, ro, eo} !== 3'b101) begin
      bad = bad + 1;
      $display("FAIL set_drive: S,R,FfEn=%b required 101", {so, ro, eo});
    end
    total = total + 1;
    if (dc !== 3) begin
      bad = bad + 1;
      $display("FAIL set_latency: Done cycle=%0d required 3", dc);
    end
    total = total + 1;
    if ({mo, fo} !== 2'b10) begin
      bad = bad + 1;
      $display("FAIL set_result: Match,Fault=%b required 10", {mo, fo});
    end
    // Same target again: hold
    issue(1'b1, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if ({so, ro, eo} !== 3'b001) begin
      bad = bad + 1;
      $display("FAIL hold_drive: S,R,FfEn=%b required 001", {so, ro, eo});
    end
    total = total + 1;
    if (dc !== 3 || mo !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL hold_result: Done cycle=%0d Match=%b required 3 1", dc, mo);
    end
    // Target 0 after Q=1: reset excitation
    issue(1'b0, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if ({so, ro, eo} !== 3'b011) begin
      bad = bad + 1;
      $display("FAIL rst_drive: S,R,FfEn=%b required 011", {so, ro, eo});
    end
    total = total + 1;
    if ({mo, fo} !== 2'b10) begin
      bad = bad + 1;
      $display("FAIL rst_result: Match,Fault=%b required 10", {mo, fo});
    end
  endtask

  task automatic test_fault;
    logic so, ro, eo, mo, fo;
    int dc;
    stuck = 1'b1;
    issue(1'b1, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if (dc !== 3 || {mo, fo} !== 2'b01) begin
      bad = bad + 1;
      $display("FAIL fault_result: Done cycle=%0d Match,Fault=%b required 3 01", dc, {mo, fo});
    end
`ifdef SR_ERR_COUNT_EN
    total = total + 1;
    if (errcnt !== 8'd1) begin
      bad = bad + 1;
      $display("FAIL fault_errcnt: ErrCnt=%0d required 1", errcnt);
    end
`endif
    // CurQ is now 1. A fault check clears Known, so the same target still drives S.
    issue(1'b1, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if ({so, ro, eo} !== 3'b101) begin
      bad = bad + 1;
      $display("FAIL fault_reexcite: S,R,FfEn=%b required 101", {so, ro, eo});
    end
`ifdef SR_ERR_COUNT_EN
    for (int i = 0; i < 298; i++) issue(1'b1, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if (errcnt !== 8'd255) begin
      bad = bad + 1;
      $display("FAIL errcnt_saturate: ErrCnt=%0d required 255", errcnt);
    end
`endif
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back;
    int last, ndone, rdy_cnt;
    last = -1; ndone = 0; rdy_cnt = 0;
    tq3 = 1'b1; tv3 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (rdy3) rdy_cnt++;
      if (done3) begin
        total = total + 1;
        if (rdy3 !== 1'b0 || match3 !== 1'b1) begin
          bad = bad + 1;
          $display("FAIL b2b_done: TgtReady=%b Match=%b required 0 1", rdy3, match3);
        end
        if (last >= 0) begin
          total = total + 1;
          if (c - last != 6) begin
            bad = bad + 1;
            $display("FAIL b2b_spacing: Done spacing=%0d required 6", c - last);
          end
          total = total + 1;
          if (rdy_cnt != 1) begin
            bad = bad + 1;
            $display("FAIL b2b_ready: TgtReady cycles per period=%0d required 1", rdy_cnt);
          end
        end
        rdy_cnt = 0;
        last = c;
        ndone++;
      end
    end
    total = total + 1;
    if (ndone != 6) begin
      bad = bad + 1;
      $display("FAIL b2b_count: Done pulses=%0d required 6", ndone);
    end
    @(posedge Clk); #1 tv3 = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_inflight;
    logic so, ro, eo, mo, fo;
    int dc, ndone;
    tv = 1'b1; tq = 1'b1;
    @(negedge Clk);                 // cycle 0
    @(posedge Clk); #1 tv = 1'b0;   // cycle 1 (DRIVE)
    @(posedge Clk); #1 Rst = 1'b1;  // cycle 2 (SETTLE)
    @(posedge Clk); #1 Rst = 1'b0;  // cycle 3: reset values, no CHECK
    @(negedge Clk);
    total = total + 1;
    if ({s, r, en, done, match, fault, rdy} !== 7'b0000001) begin
      bad = bad + 1;
      $display("FAIL rst_inflight_outputs: S,R,FfEn,Done,Match,Fault,TgtReady=%b required 0000001",
               {s, r, en, done, match, fault, rdy});
    end
`ifdef SR_ERR_COUNT_EN
    total = total + 1;
    if (errcnt !== 8'd0) begin
      bad = bad + 1;
      $display("FAIL rst_inflight_errcnt: ErrCnt=%0d required 0", errcnt);
    end
`endif
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (done) ndone++;
    end
    total = total + 1;
    if (ndone != 0) begin
      bad = bad + 1;
      $display("FAIL rst_inflight_nodone: Done pulses=%0d required 0", ndone);
    end
    @(posedge Clk); #1;
    // Known=0 after reset: target 0 with CurQ=0 still drives R
    issue(1'b0, so, ro, eo, dc, mo, fo);
    total = total + 1;
    if ({so, ro, eo} !== 3'b011) begin
      bad = bad + 1;
      $display("FAIL rst_reexcite: S,R,FfEn=%b required 011", {so, ro, eo});
    end
    total = total + 1;
    if (dc !== 3 || {mo, fo} !== 2'b10) begin
      bad = bad + 1;
      $display("FAIL rst_reexcite_result: Done cycle=%0d Match,Fault=%b required 3 10", dc, {mo, fo});
    end
  endtask

  initial begin
    test_reset();
    test_set_hold_reset();
    test_fault();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
